// File: rtl/rf_writeback.sv
// rf_writeback: register-file write port arbiter (ALU first, buffered loads second)
// plus busy scoreboard. Optional WB_PERF_EN adds write/stall performance counters.
module rf_writeback #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] RD_Back,
  output logic            Control,
  output logic [31:0]     busy
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     perf_wr_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t         mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            ctrl_q, ctrl_d;
  logic [31:0]     busy_q, busy_d;

  logic            push, pop;
  logic            sel_vld;
  wb_ent_t         sel;
  wb_ent_t         lsu_ent;

  assign lsu_ready = (cnt_q != FULL);
  assign push      = lsu_valid && lsu_ready;
  assign lsu_ent   = '{rd: lsu_rd, data: lsu_data};

  // ALU has no backpressure, so it always wins; loads wait in the FIFO.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    pop     = 1'b0;
    if (alu_valid) begin
      sel_vld = 1'b1;
      sel     = '{rd: alu_rd, data: alu_data};
    end else if (cnt_q != '0) begin
      sel_vld = 1'b1;
      sel     = mem_q[rptr_q];
      pop     = 1'b1;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    ctrl_d = sel_vld && (sel.rd != 5'd0);
    rd_d   = rd_q;
    data_d = data_q;
    if (ctrl_d) begin
      rd_d   = sel.rd;
      data_d = sel.data;
    end
  end

  // Set after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (sel_vld) busy_d[sel.rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= lsu_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      ctrl_q <= 1'b0;
      busy_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      busy_q <= busy_d;
    end
  end

  assign RD      = rd_q;
  assign RD_Back = data_q;
  assign Control = ctrl_q;
  assign busy    = busy_q;

`ifdef WB_PERF_EN
  logic [31:0] pwr_q, pstall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwr_q    <= '0;
      pstall_q <= '0;
    end else begin
      if (ctrl_q) pwr_q <= pwr_q + 32'd1;
      if (lsu_valid && !lsu_ready) pstall_q <= pstall_q + 32'd1;
    end
  end

  assign perf_wr_cnt    = pwr_q;
  assign perf_stall_cnt = pstall_q;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed + random stimulus against a queue-based
// reference model of the write-back arbiter and scoreboard.
module tb_rf_writeback;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [4:0]      RD;
  logic [XLEN-1:0] RD_Back;
  logic            Control;
  logic [31:0]     busy;
`ifdef WB_PERF_EN
  logic [31:0]     perf_wr_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  rf_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .RD          (RD),
    .RD_Back     (RD_Back),
    .Control     (Control),
    .busy        (busy)
`ifdef WB_PERF_EN
    ,
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mbusy;
  logic        mctrl;
  logic [4:0]  mrd;
  logic [63:0] mdata;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy = '0;
    mctrl = 1'b0;
    mrd   = '0;
    mdata = '0;
  endtask

  task automatic model_step();
    bit   ready;
    bit   s_v;
    ent_t s;
    ent_t e;
    ready = (mq.size() != DEPTH);
    s_v   = 1'b0;
    s.rd  = '0;
    s.d   = '0;
    if (alu_valid) begin
      s_v  = 1'b1;
      s.rd = alu_rd;
      s.d  = alu_data;
    end else if (mq.size() > 0) begin
      s_v = 1'b1;
      s   = mq.pop_front();
    end
    if (lsu_valid && ready) begin
      e.rd = lsu_rd;
      e.d  = lsu_data;
      mq.push_back(e);
    end
    mctrl = s_v && (s.rd != 0);
    if (mctrl) begin
      mrd   = s.rd;
      mdata = s.d;
    end
    if (s_v) mbusy[s.rd] = 1'b0;
    if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    mbusy[0] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("ctrl",  {63'd0, Control},   {63'd0, mctrl});
    check("rd",    {59'd0, RD},        {59'd0, mrd});
    check("data",  RD_Back,            mdata);
    check("busy",  {32'd0, busy},      {32'd0, mbusy});
    check("ready", {63'd0, lsu_ready}, {63'd0, (mq.size() != DEPTH)});
  endtask

  task automatic idle_in();
    issue_valid = 0; issue_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    model_reset();
    #13;
    check("rst_ctrl",  {63'd0, Control},   64'd0);
    check("rst_rd",    {59'd0, RD},        64'd0);
    check("rst_data",  RD_Back,            64'd0);
    check("rst_busy",  {32'd0, busy},      64'd0);
    check("rst_ready", {63'd0, lsu_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    step();
    check("alu_ctrl", {63'd0, Control}, 64'd1);
    check("alu_rd",   {59'd0, RD},      64'd5);
    check("alu_data", RD_Back,          64'h1234);
    idle_in();
    step();
    check("alu_once", {63'd0, Control}, 64'd0);

    // ALU priority over load
    alu_valid = 1; alu_rd = 3; alu_data = 64'hA;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'hB;
    step();
    check("pri_rd1", {59'd0, RD}, 64'd3);
    check("pri_d1",  RD_Back,     64'hA);
    idle_in();
    step();
    check("pri_ctrl2", {63'd0, Control}, 64'd1);
    check("pri_rd2",   {59'd0, RD},      64'd4);
    check("pri_d2",    RD_Back,          64'hB);
    step();

    // Full FIFO under continuous ALU traffic
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(1 + i); alu_data = 64'(100 + i);
      lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 64'(200 + i);
      step();
    end
    check("full_ready0", {63'd0, lsu_ready}, 64'd0);
    lsu_rd = 20; lsu_data = 64'hDEAD;
    step();
    check("full_stall", {63'd0, lsu_ready}, 64'd0);
    idle_in();
    step();
    check("drain_rd0",  {59'd0, RD},        64'd10);
    check("drain_rdy1", {63'd0, lsu_ready}, 64'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_rd", {59'd0, RD}, 64'(10 + i));
      check("drain_d",  RD_Back,     64'(200 + i));
    end
    step();
    check("drain_done", {63'd0, Control}, 64'd0);

    // x0 destination
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
    step();
    check("x0_ctrl", {63'd0, Control}, 64'd0);
    check("x0_rd",   {59'd0, RD},      64'd13);
    check("x0_busy", {32'd0, busy},    64'd0);
    idle_in();

    // Scoreboard set/clear
    issue_valid = 1; issue_rd = 7;
    step();
    check("sb_set", {63'd0, busy[7]}, 64'd1);
    alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
    step();
    check("sb_setwins", {63'd0, busy[7]}, 64'd1);
    issue_valid = 0;
    step();
    check("sb_clear", {63'd0, busy[7]}, 64'd0);
    issue_valid = 1; issue_rd = 0; alu_valid = 0;
    step();
    check("sb_x0", {63'd0, busy[0]}, 64'd0);
    idle_in();

    // Async reset mid-drain with two entries queued
    issue_valid = 1; issue_rd = 9;
    alu_valid = 1; alu_rd = 2; alu_data = 64'h2;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h9;
    step();
    issue_rd = 11; lsu_rd = 11; lsu_data = 64'h11;
    step();
    lsu_rd = 12; lsu_data = 64'h12; issue_rd = 12;
    step();
    idle_in();
    step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_ctrl",  {63'd0, Control},   64'd0);
    check("arst_busy",  {32'd0, busy},      64'd0);
    check("arst_ready", {63'd0, lsu_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_nowr", {63'd0, Control}, 64'd0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      alu_valid   = ($urandom_range(0, 3) == 0);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = {$urandom, $urandom};
      lsu_valid   = ($urandom_range(0, 1) == 0);
      lsu_rd      = 5'($urandom_range(0, 31));
      lsu_data    = {$urandom, $urandom};
      step();
    end
    idle_in();
    for (int i = 0; i < 6; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
